// File: rtl/output_queue_demux_pkg.sv
// Shared definitions for the output queue demultiplexer: FSM encoding and the
// location of the destination bits inside tuser.
package output_queue_demux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_DROP = 2'd2
   } state_e;

   // Queue N is requested by tuser[DEST_OFFSET + PORT_STRIDE*N]
   localparam int DEST_OFFSET = 24;
   localparam int PORT_STRIDE = 2;

endpackage

// File: rtl/output_queue_demux.sv
// Routes one AXI4-Stream input to up to four output queues using tuser[31:24].
// Define OUTPUT_DEMUX_MULTICAST_EN to replicate to every requested queue;
// otherwise only the lowest-numbered requested queue receives the packet.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for / handling the first beat of a packet
// ST_FWD  | forwarding remaining beats of a packet to the latched mask
// ST_DROP | discarding remaining beats of a packet with no destination
module output_queue_demux
   import output_queue_demux_pkg::*;
#(
   parameter int C_AXIS_DATA_WIDTH  = 256,
   parameter int C_AXIS_TUSER_WIDTH = 128,
   parameter int C_NUM_QUEUES       = 4,
   parameter int C_NUM_QUEUES_WIDTH = 2
) (
   input  logic                            axis_clk,
   input  logic                            reset,

   input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                            s_axis_tlast,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,

   output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_0,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_0,
   output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_0,
   output logic                            m_axis_tlast_0,
   output logic                            m_axis_tvalid_0,
   input  logic                            m_axis_tready_0,

   output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_1,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_1,
   output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_1,
   output logic                            m_axis_tlast_1,
   output logic                            m_axis_tvalid_1,
   input  logic                            m_axis_tready_1,

   output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_2,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_2,
   output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_2,
   output logic                            m_axis_tlast_2,
   output logic                            m_axis_tvalid_2,
   input  logic                            m_axis_tready_2,

   output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_3,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_3,
   output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_3,
   output logic                            m_axis_tlast_3,
   output logic                            m_axis_tvalid_3,
   input  logic                            m_axis_tready_3,

   output logic [31:0]                     drop_count
);

   state_e                  state_q, state_d;
   logic [C_NUM_QUEUES-1:0] mask_q, mask_d;
   logic [31:0]             drop_count_q, drop_count_d;
   logic [C_NUM_QUEUES-1:0] req, mask_new, mask_cur, taken;
   logic [C_NUM_QUEUES-1:0] tvalid_m, tready_m, take;
   logic                    fwd_path, drop_path, beat_done;

   assign tready_m = {m_axis_tready_3, m_axis_tready_2, m_axis_tready_1, m_axis_tready_0};

   always_comb begin
      req = '0;
      for (int n = 0; n < C_NUM_QUEUES; n++) begin
         req[n] = s_axis_tuser[DEST_OFFSET + PORT_STRIDE*n];
      end
   end

`ifdef OUTPUT_DEMUX_MULTICAST_EN
   logic [C_NUM_QUEUES-1:0] taken_q, taken_d;

   assign mask_new = req;
   assign taken    = taken_q;
   assign taken_d  = beat_done ? '0 : (taken_q | take);

   always_ff @(posedge axis_clk or posedge reset) begin
      if (reset) taken_q <= '0;
      else       taken_q <= taken_d;
   end
`else
   logic [C_NUM_QUEUES_WIDTH-1:0] sel_idx;

   always_comb begin
      sel_idx = '0;
      for (int n = C_NUM_QUEUES-1; n >= 0; n--) begin
         if (req[n]) sel_idx = C_NUM_QUEUES_WIDTH'(n);
      end
      mask_new = '0;
      if (|req) mask_new[sel_idx] = 1'b1;
   end

   assign taken = '0;
`endif

   // Valid depends on tvalid, tuser and registered state only, never on tready.
   always_comb begin
      mask_cur  = (state_q == ST_FWD) ? mask_q : mask_new;
      fwd_path  = (state_q == ST_FWD)  || ((state_q == ST_IDLE) && (|req));
      drop_path = (state_q == ST_DROP) || ((state_q == ST_IDLE) && !(|req));
      tvalid_m  = (s_axis_tvalid && fwd_path) ? (mask_cur & ~taken) : '0;
      take      = tvalid_m & tready_m;
      beat_done = s_axis_tvalid && fwd_path && ((mask_cur & ~taken & ~take) == '0);
   end

   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      drop_count_d = drop_count_q;
      case (state_q)
         ST_IDLE: begin
            if (s_axis_tvalid) begin
               if (drop_path) begin
                  drop_count_d = drop_count_q + 32'd1;
                  if (!s_axis_tlast) state_d = ST_DROP;
               end else if (beat_done && !s_axis_tlast) begin
                  mask_d  = mask_cur;
                  state_d = ST_FWD;
               end
            end
         end
         ST_FWD: begin
            if (beat_done && s_axis_tlast) begin
               mask_d  = '0;
               state_d = ST_IDLE;
            end
         end
         ST_DROP: begin
            if (s_axis_tvalid && s_axis_tlast) state_d = ST_IDLE;
         end
         default: begin
            mask_d  = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge axis_clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         mask_q       <= '0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         mask_q       <= mask_d;
         drop_count_q <= drop_count_d;
      end
   end

   // Handshake outputs are forced low while reset is held, not just after an edge.
   assign s_axis_tready   = !reset && (drop_path || beat_done);
   assign m_axis_tvalid_0 = !reset && tvalid_m[0];
   assign m_axis_tvalid_1 = !reset && tvalid_m[1];
   assign m_axis_tvalid_2 = !reset && tvalid_m[2];
   assign m_axis_tvalid_3 = !reset && tvalid_m[3];
   assign drop_count      = drop_count_q;

   assign m_axis_tdata_0 = s_axis_tdata;
   assign m_axis_tkeep_0 = s_axis_tkeep;
   assign m_axis_tuser_0 = s_axis_tuser;
   assign m_axis_tlast_0 = s_axis_tlast;
   assign m_axis_tdata_1 = s_axis_tdata;
   assign m_axis_tkeep_1 = s_axis_tkeep;
   assign m_axis_tuser_1 = s_axis_tuser;
   assign m_axis_tlast_1 = s_axis_tlast;
   assign m_axis_tdata_2 = s_axis_tdata;
   assign m_axis_tkeep_2 = s_axis_tkeep;
   assign m_axis_tuser_2 = s_axis_tuser;
   assign m_axis_tlast_2 = s_axis_tlast;
   assign m_axis_tdata_3 = s_axis_tdata;
   assign m_axis_tkeep_3 = s_axis_tkeep;
   assign m_axis_tuser_3 = s_axis_tuser;
   assign m_axis_tlast_3 = s_axis_tlast;

endmodule

// File: doc/output_queue_demux.md
OUTPUT_QUEUE_DEMUX -- requirements
Module: output_queue_demux

Interface
REQ-001 Parameter C_AXIS_DATA_WIDTH, default 256, SHALL set the tdata width; tkeep is C_AXIS_DATA_WIDTH/8.
REQ-002 Parameter C_AXIS_TUSER_WIDTH, default 128, SHALL set the tuser width.
REQ-003 Parameter C_NUM_QUEUES, default 4, SHALL set the number of output queues; C_NUM_QUEUES_WIDTH, default 2, is its log2.
REQ-004 Port axis_clk, input, 1 bit, SHALL be the single clock.
REQ-005 Port reset, input, 1 bit, SHALL be an asynchronous, active-high reset.
REQ-006 Ports s_axis_tdata/tkeep/tuser/tlast/tvalid (inputs) and s_axis_tready (output) SHALL form the single AXI4-Stream slave from the match-action pipeline.
REQ-007 Ports m_axis_tdata_N/tkeep_N/tuser_N/tlast_N/tvalid_N (outputs) and m_axis_tready_N (input), N=0..3, SHALL form one AXI4-Stream master per output queue, feeding output_arbiter-class slaves.
REQ-008 Port drop_count, output, 32 bits, SHALL count dropped packets.

Function
REQ-009 tdata, tkeep, tuser and tlast SHALL fan out combinationally to every master; only tvalid_N and s_axis_tready are gated.
REQ-010 Destination SHALL come from tuser[31:24] on the first beat; queue N is requested when tuser[24+2*N] = 1.
REQ-011 The FSM SHALL have states IDLE, FWD and DROP.
REQ-012 In IDLE with s_axis_tvalid=1, mask = requested-queue set; mask=0 SHALL select the drop path and mask!=0 the forward path.
REQ-013 In IDLE on the forward path, each master in mask that has not yet taken the beat SHALL have tvalid_N=1; all other masters SHALL have tvalid_N=0.
REQ-014 A master SHALL take a beat when its tvalid_N and tready_N are both 1; a per-beat "taken" register SHALL record this.
REQ-015 A master that has taken the current beat SHALL have tvalid_N=0 until the beat completes.
REQ-016 A beat SHALL complete in the cycle its last outstanding master takes it; s_axis_tready=1 only in that cycle, and "taken" then clears.
REQ-017 The mask SHALL be latched on completion of a first beat with tlast=0, with a transition IDLE->FWD; it SHALL hold until the tlast beat completes, then FWD->IDLE.
REQ-018 A single-beat packet SHALL complete in IDLE and remain in IDLE.
REQ-019 tvalid_N SHALL NOT depend combinationally on tready_N of the same port.
REQ-020 On the drop path, s_axis_tready SHALL be 1 and all tvalid_N SHALL be 0.
REQ-021 A dropped first beat with tlast=0 SHALL cause IDLE->DROP; the FSM SHALL discard beats until tlast, then DROP->IDLE.
REQ-022 drop_count SHALL increment by 1 per dropped packet, on its first beat, and wrap from 0xFFFFFFFF to 0.
REQ-023 tuser on non-first beats SHALL be ignored for routing.
REQ-024 Back-to-back packets SHALL be accepted with zero idle cycles between tlast and the next first beat.

Reset
REQ-025 Asserting reset SHALL force state=IDLE, mask=0, taken=0, drop_count=0, all tvalid_N=0 and s_axis_tready=0, immediately and irrespective of the clock.
REQ-026 A packet in flight at reset SHALL be abandoned; after release, the next beat seen is treated as a first beat.

Configuration
REQ-027 With macro OUTPUT_DEMUX_MULTICAST_EN defined, mask SHALL be the full requested set (replication per REQ-013 to REQ-016).
REQ-028 Without OUTPUT_DEMUX_MULTICAST_EN, mask SHALL be one-hot on the lowest-numbered requested queue, and the taken register is unused.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the tuser destination-field offset (24) and the port-bit stride (2).
REQ-030 No sub-module SHALL be instantiated; output buffering stays in the downstream arbiter FIFOs.

Verification
REQ-031 Unicast: 3-beat packet with tuser[31:24]=0x04, all tready=1 -> 3 beats on master 1 only; s_axis_tready=1 each cycle; drop_count=0.
REQ-032 Drop: 2 packets with tuser[31:24]=0x00 -> no tvalid_N ever asserted; s_axis_tready=1 throughout; drop_count=2.
REQ-033 Multicast (macro on): tuser[31:24]=0x41; tready_0=1, tready_3 low for 2 cycles -> master 0 sees each beat once; beat completes when master 3 takes it; no duplicate beats.
REQ-034 Unicast fallback (macro off): tuser[31:24]=0x41 -> packet on master 0 only.
REQ-035 Back-pressure: tready_2 toggling 1/0 during a 4-beat packet to queue 2 -> beats in order, none lost, tdata stable while tvalid_2=1.
REQ-036 Reset in FWD mid-packet -> all outputs 0 asynchronously; next beat after release is routed by its own tuser.
